// File: rtl/apb_slave_fabric_if.sv
// apb_slave_fabric_if: upstream APB (from the AXI-APB bridge) and downstream fan-out bus of apb_slave_fabric.
// The slave modport is the fabric's view; the master modport is the bridge/peripheral side.
interface apb_slave_fabric_if #(
  parameter int unsigned NumSlaves = 4
);
  logic [31:0]             p_addr;
  logic                    p_sel;
  logic                    p_enable;
  logic                    p_write;
  logic [31:0]             p_wdata;
  logic [31:0]             p_rdata;
  logic                    p_ready;
  logic                    p_slverr;

  logic [NumSlaves-1:0]    s_sel;
  logic                    s_enable;
  logic [31:0]             s_addr;
  logic                    s_write;
  logic [31:0]             s_wdata;
  logic [32*NumSlaves-1:0] s_rdata;
  logic [NumSlaves-1:0]    s_ready;
  logic [NumSlaves-1:0]    s_slverr;

  modport slave (
    input  p_addr, p_sel, p_enable, p_write, p_wdata,
    output p_rdata, p_ready, p_slverr,
    output s_sel, s_enable, s_addr, s_write, s_wdata,
    input  s_rdata, s_ready, s_slverr
  );

  modport master (
    output p_addr, p_sel, p_enable, p_write, p_wdata,
    input  p_rdata, p_ready, p_slverr,
    input  s_sel, s_enable, s_addr, s_write, s_wdata,
    output s_rdata, s_ready, s_slverr
  );
endinterface

// File: rtl/apb_slave_fabric.sv
// apb_slave_fabric: latches one upstream APB transfer, decodes the target region and replays it downstream.
// Define APB_TIMEOUT_EN to abort ACCESS phases that stall for TimeoutCycles cycles.
module apb_slave_fabric #(
  parameter int unsigned NumSlaves     = 4,
  parameter logic [31:0] BaseAddr      = 32'h4000_0000,
  parameter int unsigned RegionBits    = 12,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic              a_clk,
  input  logic              a_reset_n,
  apb_slave_fabric_if.slave bus
);
  localparam int unsigned IdxW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

  if (NumSlaves < 1 || NumSlaves > 16 || TimeoutCycles < 2) begin : g_param_err
    $error("apb_slave_fabric: NumSlaves must be 1..16 and TimeoutCycles >= 2");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e               state_q, state_d;
  logic [NumSlaves-1:0] s_sel_q, s_sel_d;
  logic                 s_enable_q, s_enable_d;
  logic [31:0]          s_addr_q, s_addr_d;
  logic                 s_write_q, s_write_d;
  logic [31:0]          s_wdata_q, s_wdata_d;
  logic [31:0]          p_rdata_q, p_rdata_d;
  logic                 p_slverr_q, p_slverr_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 abort_q, abort_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles);
  logic [CntW-1:0]      tmo_cnt_q, tmo_cnt_d;
`endif

  logic [31:0]          off_c, idx_full_c;
  logic                 mapped_c;
  logic [IdxW-1:0]      dec_idx_c;
  logic [NumSlaves-1:0] sel_onehot_c;
  logic [31:0]          slv_rdata_c;
  logic                 slv_ready_c, slv_err_c, p_ready_c;

  // Region decode; the >= guard keeps addresses below the window from wrapping into it.
  assign off_c      = bus.p_addr - BaseAddr;
  assign idx_full_c = off_c >> RegionBits;
  assign mapped_c   = (bus.p_addr >= BaseAddr) && (idx_full_c < 32'(NumSlaves));
  assign dec_idx_c  = IdxW'(idx_full_c);
  assign p_ready_c  = (state_q == RESP) && bus.p_enable;

  always_comb begin : slave_mux
    sel_onehot_c = '0;
    slv_rdata_c  = '0;
    slv_ready_c  = 1'b0;
    slv_err_c    = 1'b0;
    for (int unsigned i = 0; i < NumSlaves; i++) begin
      sel_onehot_c[i] = (dec_idx_c == IdxW'(i));
      if (idx_q == IdxW'(i)) begin
        slv_rdata_c = bus.s_rdata[32*i +: 32];
        slv_ready_c = bus.s_ready[i];
        slv_err_c   = bus.s_slverr[i];
      end
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    s_sel_d    = s_sel_q;
    s_enable_d = s_enable_q;
    s_addr_d   = s_addr_q;
    s_write_d  = s_write_q;
    s_wdata_d  = s_wdata_q;
    p_rdata_d  = p_rdata_q;
    p_slverr_d = p_slverr_q;
    idx_d      = idx_q;
    abort_d    = abort_q;
`ifdef APB_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.p_sel) begin
          s_addr_d  = bus.p_addr;
          s_write_d = bus.p_write;
          s_wdata_d = bus.p_wdata;
          idx_d     = dec_idx_c;
          abort_d   = 1'b0;
          if (mapped_c) begin
            state_d = SETUP;
            s_sel_d = sel_onehot_c;
`ifdef APB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end else begin
            state_d    = RESP;
            p_rdata_d  = '0;
            p_slverr_d = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        s_enable_d = 1'b1;
        abort_d    = abort_q | ~bus.p_sel;
      end
      ACCESS: begin
        // An upstream that dropped p_sel still gets its downstream cycle finished, but no response.
        abort_d = abort_q | ~bus.p_sel;
        if (slv_ready_c) begin
          s_sel_d    = '0;
          s_enable_d = 1'b0;
          state_d    = abort_d ? IDLE : RESP;
          if (!abort_d) begin
            p_rdata_d  = s_write_q ? 32'h0 : slv_rdata_c;
            p_slverr_d = slv_err_c;
          end
        end
`ifdef APB_TIMEOUT_EN
        else if (tmo_cnt_q == CntW'(TimeoutCycles - 1)) begin
          s_sel_d    = '0;
          s_enable_d = 1'b0;
          state_d    = abort_d ? IDLE : RESP;
          if (!abort_d) begin
            p_rdata_d  = 32'h0;
            p_slverr_d = 1'b1;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + CntW'(1);
        end
`endif
      end
      RESP: begin
        if (p_ready_c || !bus.p_sel) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge a_clk or negedge a_reset_n) begin : regs
    if (!a_reset_n) begin
      state_q    <= IDLE;
      s_sel_q    <= '0;
      s_enable_q <= 1'b0;
      s_addr_q   <= '0;
      s_write_q  <= 1'b0;
      s_wdata_q  <= '0;
      p_rdata_q  <= '0;
      p_slverr_q <= 1'b0;
      idx_q      <= '0;
      abort_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      s_sel_q    <= s_sel_d;
      s_enable_q <= s_enable_d;
      s_addr_q   <= s_addr_d;
      s_write_q  <= s_write_d;
      s_wdata_q  <= s_wdata_d;
      p_rdata_q  <= p_rdata_d;
      p_slverr_q <= p_slverr_d;
      idx_q      <= idx_d;
      abort_q    <= abort_d;
`ifdef APB_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
`endif
    end
  end

  assign bus.s_sel    = s_sel_q;
  assign bus.s_enable = s_enable_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.s_write  = s_write_q;
  assign bus.s_wdata  = s_wdata_q;
  assign bus.p_rdata  = p_rdata_q;
  assign bus.p_slverr = p_slverr_q;
  assign bus.p_ready  = p_ready_c;
endmodule

// File: tb/tb_apb_slave_fabric.sv
// Directed bench for apb_slave_fabric: four modelled peripherals with per-slave wait states, data and error.
module tb_apb_slave_fabric;
  logic a_clk = 1'b0;
  logic a_reset_n;
  int   checks = 0;
  int   errors = 0;

  apb_slave_fabric_if #(.NumSlaves(4)) bus ();

  apb_slave_fabric #(
    .NumSlaves(4), .BaseAddr(32'h4000_0000), .RegionBits(12), .TimeoutCycles(8)
  ) dut (
    .a_clk(a_clk), .a_reset_n(a_reset_n), .bus(bus)
  );

  always #5 a_clk = ~a_clk;

  // Peripheral model: slave i is ready once it has spent wait_cfg[i] cycles in ACCESS.
  int          wait_cfg [4];
  logic [31:0] rdata_cfg[4];
  logic [3:0]  err_cfg, stray_rdy, stray_err;
  int          acc_cnt  [4];

  always @(posedge a_clk)
    for (int i = 0; i < 4; i++)
      acc_cnt[i] <= (bus.s_sel[i] && bus.s_enable) ? acc_cnt[i] + 1 : 0;

  always_comb begin
    bus.s_ready  = '0;
    bus.s_slverr = '0;
    bus.s_rdata  = '0;
    for (int i = 0; i < 4; i++) begin
      bus.s_ready[i]         = stray_rdy[i] | (bus.s_sel[i] & bus.s_enable & (acc_cnt[i] >= wait_cfg[i]));
      bus.s_slverr[i]        = err_cfg[i] | stray_err[i];
      bus.s_rdata[32*i +: 32] = rdata_cfg[i];
    end
  end

  logic [3:0]  sel_hist[16];
  logic        en_hist [16];
  logic [31:0] addr_c1, wdata_c1;
  logic        write_c1;

  // Upstream driver: cycle 0 is the setup cycle; rc is the cycle p_ready was seen, -1 if never.
  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input int limit, output int rc, output logic [31:0] rd, output logic er);
    rc = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 16; i++) begin sel_hist[i] = '0; en_hist[i] = 1'b0; end
    @(posedge a_clk); #1;
    bus.p_sel = 1'b1; bus.p_enable = 1'b0;
    bus.p_addr = addr; bus.p_write = wr; bus.p_wdata = wdata;
    for (int c = 0; c <= limit; c++) begin
      if (c > 0) begin @(posedge a_clk); #1; end
      if (c == 1) bus.p_enable = 1'b1;
      @(negedge a_clk);
      if (c < 16) begin sel_hist[c] = bus.s_sel; en_hist[c] = bus.s_enable; end
      if (c == 1) begin addr_c1 = bus.s_addr; wdata_c1 = bus.s_wdata; write_c1 = bus.s_write; end
      if (bus.p_ready) begin rc = c; rd = bus.p_rdata; er = bus.p_slverr; break; end
    end
  endtask

  task automatic go_idle();
    @(posedge a_clk); #1;
    bus.p_sel = 1'b0; bus.p_enable = 1'b0;
  endtask

  task automatic test_reset();
    a_reset_n = 1'b0;
    bus.p_sel = 1'b0; bus.p_enable = 1'b1; bus.p_write = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
    #12;
    checks++;
    if (bus.s_sel !== 4'b0 || bus.s_enable !== 1'b0 || bus.s_addr !== 32'h0 || bus.s_write !== 1'b0 ||
        bus.s_wdata !== 32'h0 || bus.p_rdata !== 32'h0 || bus.p_slverr !== 1'b0 || bus.p_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: s_sel=%b s_en=%b s_addr=%h s_wr=%b s_wdata=%h p_rdata=%h p_slverr=%b p_ready=%b, expected all zero",
               bus.s_sel, bus.s_enable, bus.s_addr, bus.s_write, bus.s_wdata, bus.p_rdata, bus.p_slverr, bus.p_ready);
    end
    bus.p_enable = 1'b0;
    @(posedge a_clk); #1;
    a_reset_n = 1'b1;
  endtask

  task automatic test_write();
    int rc; logic [31:0] rd; logic er;
    rdata_cfg[1] = 32'hDEAD_BEEF;
    apb_xfer(32'h4000_1008, 1'b1, 32'hA5A5_0001, 20, rc, rd, er);
    checks++;
    if (sel_hist[0] !== 4'b0000 || sel_hist[1] !== 4'b0010 || en_hist[1] !== 1'b0) begin
      errors++; $display("FAIL write_setup: s_sel c0=%b c1=%b s_en c1=%b, expected 0000 0010 0", sel_hist[0], sel_hist[1], en_hist[1]);
    end
    checks++;
    if (sel_hist[2] !== 4'b0010 || en_hist[2] !== 1'b1) begin
      errors++; $display("FAIL write_access: s_sel=%b s_en=%b at c2, expected 0010 1", sel_hist[2], en_hist[2]);
    end
    checks++;
    if (addr_c1 !== 32'h4000_1008 || wdata_c1 !== 32'hA5A5_0001 || write_c1 !== 1'b1) begin
      errors++; $display("FAIL write_payload: addr=%h wdata=%h write=%b, expected 40001008 a5a50001 1", addr_c1, wdata_c1, write_c1);
    end
    checks++;
    if (rc !== 3 || er !== 1'b0 || rd !== 32'h0 || sel_hist[3] !== 4'b0) begin
      errors++; $display("FAIL write_resp: ready_cycle=%0d slverr=%b rdata=%h s_sel=%b, expected 3 0 00000000 0000", rc, er, rd, sel_hist[3]);
    end
    go_idle();
  endtask

  task automatic test_read_wait();
    int rc; logic [31:0] rd; logic er;
    wait_cfg[3] = 2; rdata_cfg[3] = 32'h1234_5678;
    apb_xfer(32'h4000_3000, 1'b0, 32'h0, 20, rc, rd, er);
    checks++;
    if (rc !== 5 || rd !== 32'h1234_5678 || er !== 1'b0) begin
      errors++; $display("FAIL read_wait: ready_cycle=%0d rdata=%h slverr=%b, expected 5 12345678 0", rc, rd, er);
    end
    checks++;
    if (sel_hist[1] !== 4'b1000 || write_c1 !== 1'b0 || bus.s_addr !== 32'h4000_3000) begin
      errors++; $display("FAIL read_target: s_sel=%b write=%b s_addr=%h, expected 1000 0 40003000", sel_hist[1], write_c1, bus.s_addr);
    end
    go_idle();
    wait_cfg[3] = 0;
  endtask

  task automatic test_unmapped();
    int rc; logic [31:0] rd; logic er;
    logic [31:0] addrs[2];
    addrs[0] = 32'h3FFF_FFFC; addrs[1] = 32'h4000_4000;
    for (int k = 0; k < 2; k++) begin
      apb_xfer(addrs[k], 1'b0, 32'h0, 20, rc, rd, er);
      checks++;
      if (rc !== 1 || er !== 1'b1 || rd !== 32'h0 || sel_hist[0] !== 4'b0 || sel_hist[1] !== 4'b0) begin
        errors++; $display("FAIL unmapped_%h: ready_cycle=%0d slverr=%b rdata=%h s_sel=%b/%b, expected 1 1 00000000 0000/0000",
                           addrs[k], rc, er, rd, sel_hist[0], sel_hist[1]);
      end
      go_idle();
    end
  endtask

  task automatic test_slverr_stray();
    int rc; logic [31:0] rd; logic er;
    wait_cfg[2] = 1; err_cfg = 4'b0100; stray_rdy = 4'b0001; stray_err = 4'b0001;
    apb_xfer(32'h4000_2010, 1'b1, 32'h0000_0055, 20, rc, rd, er);
    checks++;
    if (rc !== 4 || er !== 1'b1 || sel_hist[1] !== 4'b0100) begin
      errors++; $display("FAIL slverr_stray: ready_cycle=%0d slverr=%b s_sel=%b, expected 4 1 0100", rc, er, sel_hist[1]);
    end
    go_idle();
    wait_cfg[2] = 0; err_cfg = '0; stray_rdy = '0; stray_err = '0;
  endtask

  task automatic test_back_to_back();
    int rc; logic [31:0] rd; logic er;
    rdata_cfg[0] = 32'h0000_00A0;
    apb_xfer(32'h4000_0000, 1'b0, 32'h0, 20, rc, rd, er);
    checks++;
    if (rc !== 3 || rd !== 32'h0000_00A0 || er !== 1'b0) begin
      errors++; $display("FAIL b2b_first: ready_cycle=%0d rdata=%h slverr=%b, expected 3 000000a0 0", rc, rd, er);
    end
    apb_xfer(32'h4000_3FFC, 1'b0, 32'h0, 20, rc, rd, er);
    checks++;
    if (rc !== 3 || rd !== 32'h1234_5678 || sel_hist[1] !== 4'b1000) begin
      errors++; $display("FAIL b2b_second: ready_cycle=%0d rdata=%h s_sel=%b, expected 3 12345678 1000", rc, rd, sel_hist[1]);
    end
    go_idle();
  endtask

  task automatic test_abort();
    int rc; logic [31:0] rd; logic er;
    wait_cfg[0] = 2; rdata_cfg[0] = 32'hCAFE_0000; rdata_cfg[1] = 32'hDEAD_BEEF;
    @(posedge a_clk); #1;
    bus.p_sel = 1'b1; bus.p_enable = 1'b0; bus.p_addr = 32'h4000_0000; bus.p_write = 1'b0;
    @(posedge a_clk); #1; bus.p_enable = 1'b1;
    @(posedge a_clk); #1; bus.p_sel = 1'b0; bus.p_enable = 1'b0;
    @(negedge a_clk);
    checks++;
    if (bus.s_sel !== 4'b0001 || bus.s_enable !== 1'b1) begin
      errors++; $display("FAIL abort_continues: s_sel=%b s_en=%b at c2, expected 0001 1", bus.s_sel, bus.s_enable);
    end
    @(posedge a_clk); #1;
    @(posedge a_clk); #1;
    @(negedge a_clk);
    checks++;
    if (bus.s_sel !== 4'b0001 || bus.s_enable !== 1'b1 || bus.p_ready !== 1'b0) begin
      errors++; $display("FAIL abort_complete: s_sel=%b s_en=%b p_ready=%b at c4, expected 0001 1 0", bus.s_sel, bus.s_enable, bus.p_ready);
    end
    @(posedge a_clk); #1; bus.p_enable = 1'b1;
    @(negedge a_clk);
    checks++;
    if (bus.s_sel !== 4'b0 || bus.p_ready !== 1'b0 || bus.p_rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL abort_discard: s_sel=%b p_ready=%b p_rdata=%h at c5, expected 0000 0 12345678", bus.s_sel, bus.p_ready, bus.p_rdata);
    end
    bus.p_enable = 1'b0;
    apb_xfer(32'h4000_1000, 1'b0, 32'h0, 20, rc, rd, er);
    checks++;
    if (rc !== 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++; $display("FAIL abort_recover: ready_cycle=%0d rdata=%h slverr=%b, expected 3 deadbeef 0", rc, rd, er);
    end
    go_idle();
    wait_cfg[0] = 0;
  endtask

  task automatic test_timeout();
    int rc; logic [31:0] rd; logic er;
    wait_cfg[0] = 1 << 30;
    apb_xfer(32'h4000_0000, 1'b0, 32'h0, 1000, rc, rd, er);
`ifdef APB_TIMEOUT_EN
    checks++;
    if (rc !== 10 || er !== 1'b1 || rd !== 32'h0 || sel_hist[9] !== 4'b0001 || sel_hist[10] !== 4'b0000) begin
      errors++; $display("FAIL timeout_abort: ready_cycle=%0d slverr=%b rdata=%h s_sel c9=%b c10=%b, expected 10 1 00000000 0001 0000",
                         rc, er, rd, sel_hist[9], sel_hist[10]);
    end
    go_idle();
`else
    checks++;
    if (rc !== -1 || bus.s_sel !== 4'b0001 || bus.s_enable !== 1'b1) begin
      errors++; $display("FAIL timeout_wait: ready_cycle=%0d s_sel=%b s_en=%b, expected -1 0001 1", rc, bus.s_sel, bus.s_enable);
    end
    #1 a_reset_n = 1'b0;
    bus.p_sel = 1'b0; bus.p_enable = 1'b0;
    @(posedge a_clk); #1 a_reset_n = 1'b1;
`endif
    wait_cfg[0] = 0;
  endtask

  task automatic test_reset_mid();
    int rc; logic [31:0] rd; logic er;
    wait_cfg[0] = 1 << 30;
    @(posedge a_clk); #1;
    bus.p_sel = 1'b1; bus.p_enable = 1'b0; bus.p_addr = 32'h4000_0010; bus.p_write = 1'b1; bus.p_wdata = 32'h7777_0000;
    @(posedge a_clk); #1; bus.p_enable = 1'b1;
    @(posedge a_clk); #1;
    @(negedge a_clk);
    checks++;
    if (bus.s_sel !== 4'b0001 || bus.s_enable !== 1'b1) begin
      errors++; $display("FAIL reset_mid_pre: s_sel=%b s_en=%b, expected 0001 1", bus.s_sel, bus.s_enable);
    end
    #1 a_reset_n = 1'b0;
    #1;
    checks++;
    if (bus.s_sel !== 4'b0 || bus.s_enable !== 1'b0 || bus.s_addr !== 32'h0 || bus.s_write !== 1'b0 ||
        bus.s_wdata !== 32'h0 || bus.p_rdata !== 32'h0 || bus.p_slverr !== 1'b0 || bus.p_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: s_sel=%b s_en=%b s_addr=%h s_wr=%b s_wdata=%h p_rdata=%h p_slverr=%b p_ready=%b, expected all zero",
               bus.s_sel, bus.s_enable, bus.s_addr, bus.s_write, bus.s_wdata, bus.p_rdata, bus.p_slverr, bus.p_ready);
    end
    bus.p_sel = 1'b0; bus.p_enable = 1'b0;
    @(posedge a_clk); #1 a_reset_n = 1'b1;
    wait_cfg[0] = 0; rdata_cfg[0] = 32'h0BAD_F00D;
    apb_xfer(32'h4000_0004, 1'b0, 32'h0, 20, rc, rd, er);
    checks++;
    if (rc !== 3 || rd !== 32'h0BAD_F00D || er !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after: ready_cycle=%0d rdata=%h slverr=%b, expected 3 0badf00d 0", rc, rd, er);
    end
    go_idle();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin wait_cfg[i] = 0; rdata_cfg[i] = '0; end
    err_cfg = '0; stray_rdy = '0; stray_err = '0;
    test_reset();
    test_write();
    test_read_wait();
    test_unmapped();
    test_slverr_stray();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end
endmodule
